// File: rtl/i8051_pkg.sv
// Shared definitions for the 8051 fetch path: fetch state encoding, reset PC,
// instruction word field positions and the opcode length table.
package i8051_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] FETCH_OP = 2'd0;
    localparam logic [1:0] FETCH_B1 = 2'd1;
    localparam logic [1:0] FETCH_B2 = 2'd2;
    localparam logic [1:0] PRESENT  = 2'd3;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Byte lanes of the 24-bit instruction word {op_code, op_1, op_2}
    localparam int OP_CODE_LSB = 16;
    localparam int OP_1_LSB    = 8;
    localparam int OP_2_LSB    = 0;

    // 8051 instruction length in bytes; the reserved opcode 0xA5 is treated
    // as a single-byte instruction.
    function automatic logic [1:0] opcode_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if (op[3:0] == 4'h1) begin
            // AJMP / ACALL in every row
            len = 2'd2;
        end else if (op inside {8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53,
                                8'h63, 8'h75, 8'h85, 8'h90, 8'hD5, [8'hB4:8'hBF]}) begin
            len = 2'd3;
        end else if (op inside {8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40,
                                8'h42, 8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55,
                                8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72, 8'h74,
                                [8'h76:8'h7F], 8'h80, 8'h82, [8'h86:8'h8F], 8'h92,
                                8'h94, 8'h95, 8'hA0, 8'hA2, [8'hA6:8'hAF], 8'hB0,
                                8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
                                [8'hD8:8'hDF], 8'hE5, 8'hF5}) begin
            len = 2'd2;
        end
        return len;
    endfunction

endpackage

// File: rtl/opcode_len_lut.sv
// Combinational opcode -> instruction length (1..3 bytes) decoder.
module opcode_len_lut
    import i8051_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    // Pure table lookup, no state
    assign len = opcode_len(opcode);

endmodule

// File: rtl/instr_fetch.sv
// 8051 fetch stage: owns the program counter, reads program bytes from ROM
// and assembles 1..3-byte instructions for the execute datapath.
module instr_fetch
    import i8051_pkg::*;
#(
    parameter int                    PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] rom_addr,
    output logic                rom_req,
    input  logic [7:0]          rom_data,
    input  logic                rom_valid,
    output logic [23:0]         instruction,
    output logic [1:0]          instr_len,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_load_value
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          op_code;
    logic [7:0]          op_1;
    logic [7:0]          op_2;
    logic [1:0]          len_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [1:0]          dec_len;
    logic                capture;

    opcode_len_lut u_len (
        .opcode (rom_data),
        .len    (dec_len)
    );

    // NOTE: rom_req is gated by reset combinationally so no request is seen
    // while reset is held, even though the FSM already sits in FETCH_OP.
    assign rom_req     = !reset && (state != PRESENT);
    assign rom_addr    = pc;
    assign capture     = rom_req && rom_valid;
    assign instr_valid = (state == PRESENT);
    assign instr_len   = len_q;
    assign instr_pc    = pc_q;

    // Place the assembled bytes into their lanes of the instruction word
    always_comb begin
        // NOTE: every bit gets a default first so no latch is inferred.
        instruction = '0;
        instruction[OP_CODE_LSB +: 8] = op_code;
        instruction[OP_1_LSB    +: 8] = op_1;
        instruction[OP_2_LSB    +: 8] = op_2;
    end

    // FSM, PC and byte assembly; redirect overrides everything, including a
    // byte captured in the same cycle and a coincident accept.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state   <= FETCH_OP;
            pc      <= RESET_PC;
            op_code <= '0;
            op_1    <= '0;
            op_2    <= '0;
            len_q   <= '0;
            pc_q    <= '0;
        end else if (pc_load) begin
            state   <= FETCH_OP;
            pc      <= pc_load_value;
            op_code <= '0;
            op_1    <= '0;
            op_2    <= '0;
            len_q   <= '0;
            pc_q    <= '0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (capture) begin
                        op_code <= rom_data;
                        op_1    <= '0;
                        op_2    <= '0;
                        len_q   <= dec_len;
                        pc_q    <= pc;
                        pc      <= pc + PC_ONE;
                        state   <= (dec_len == 2'd1) ? PRESENT : FETCH_B1;
                    end
                end
                FETCH_B1: begin
                    if (capture) begin
                        op_1  <= rom_data;
                        pc    <= pc + PC_ONE;
                        state <= (len_q == 2'd2) ? PRESENT : FETCH_B2;
                    end
                end
                FETCH_B2: begin
                    if (capture) begin
                        op_2  <= rom_data;
                        pc    <= pc + PC_ONE;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (instr_ready) begin
                        state <= FETCH_OP;
                    end
                end
                default: state <= FETCH_OP;
            endcase
        end
    end

endmodule
